// File: rtl/instr_register_pkg.sv
// rtl/instr_register_pkg.sv - shared operand, opcode, instruction, result and exec-state types
package instr_register_pkg;

   typedef logic signed [31:0] operand_t;
   typedef logic signed [63:0] result_t;
   typedef logic [4:0]         address_t;

   // 4-bit opcode field so that out-of-set encodings can reach the unit
   typedef enum logic [3:0] {
      ZERO  = 4'd0,
      PASSA = 4'd1,
      PASSB = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4,
      MULT  = 4'd5,
      DIV   = 4'd6,
      MOD   = 4'd7
   } opcode_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
   } instruction_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      EXEC   = 3'd2,
      OUTPUT = 3'd3,
      DONE   = 3'd4
   } exec_state_t;

endpackage

// File: rtl/instr_alu.sv
// rtl/instr_alu.sv - combinational arithmetic on sign-extended operands
module instr_alu
   import instr_register_pkg::*;
(
   input  instruction_t i_instr,
   output result_t      o_result,
   output logic         o_err
);

   result_t w_a;
   result_t w_b;

   assign w_a = result_t'(i_instr.op_a);
   assign w_b = result_t'(i_instr.op_b);

   always_comb begin
      o_result = '0;
      o_err    = 1'b0;
      case (i_instr.opc)
         ZERO:  o_result = '0;
         PASSA: o_result = w_a;
         PASSB: o_result = w_b;
         ADD:   o_result = w_a + w_b;
         SUB:   o_result = w_a - w_b;
         MULT:  o_result = w_a * w_b;
         DIV: begin
            if (w_b == '0) o_err = 1'b1;
            else           o_result = w_a / w_b;
         end
         MOD: begin
            if (w_b == '0) o_err = 1'b1;
            else           o_result = w_a % w_b;
         end
         default: o_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_exec_unit.sv
// rtl/instr_exec_unit.sv - fetch/execute/output sequencer over an instruction register file
// Optional error counter output err_count enabled by INSTR_EXEC_ERRCNT_EN.
module instr_exec_unit
   import instr_register_pkg::*;
#(
   parameter int RESULT_W = 64
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  address_t                   start_addr,
   input  logic [5:0]                 num_instr,
   output address_t                   read_pointer,
   input  instruction_t               instruction_word,
   output logic                       res_valid,
   input  logic                       res_ready,
   output address_t                   res_addr,
   output logic signed [RESULT_W-1:0] result,
   output logic                       res_err,
   output logic                       busy,
`ifdef INSTR_EXEC_ERRCNT_EN
   output logic [7:0]                 err_count,
`endif
   output logic                       done
);

   exec_state_t                r_state;
   exec_state_t                w_next;
   address_t                   r_pointer;
   logic [5:0]                 r_count;
   instruction_t               r_instr;
   logic signed [RESULT_W-1:0] r_result;
   address_t                   r_res_addr;
   logic                       r_res_err;
   result_t                    w_alu_result;
   logic                       w_alu_err;
   logic                       w_accept;

   instr_alu u_alu (
      .i_instr  (r_instr),
      .o_result (w_alu_result),
      .o_err    (w_alu_err)
   );

   assign w_accept = (r_state == OUTPUT) && res_ready;

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      read_pointer = '0;
      res_valid    = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (start) w_next = (num_instr != 6'd0) ? FETCH : DONE;
         end
         FETCH: begin
            read_pointer = r_pointer;
            w_next       = EXEC;
         end
         EXEC: w_next = OUTPUT;
         OUTPUT: begin
            res_valid = 1'b1;
            if (res_ready) w_next = (r_count > 6'd1) ? FETCH : DONE;
         end
         DONE: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pointer  <= '0;
         r_count    <= '0;
         r_instr    <= '0;
         r_result   <= '0;
         r_res_addr <= '0;
         r_res_err  <= 1'b0;
      end else begin
         if (r_state == IDLE && start && num_instr != 6'd0) begin
            r_pointer <= start_addr;
            r_count   <= num_instr;
         end
         if (r_state == FETCH) r_instr <= instruction_word;
         if (r_state == EXEC) begin
            r_result   <= RESULT_W'(w_alu_result);
            r_res_addr <= r_pointer;
            r_res_err  <= w_alu_err;
         end
         // pointer is 5 bits wide, so slot 31 rolls over to 0
         if (w_accept) begin
            r_count   <= r_count - 6'd1;
            r_pointer <= r_pointer + 5'd1;
         end
      end
   end

`ifdef INSTR_EXEC_ERRCNT_EN
   logic [7:0] r_err_count;

   always_ff @(posedge clk) begin
      if (reset)                                          r_err_count <= '0;
      else if (w_accept && r_res_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
   end

   assign err_count = r_err_count;
`endif

   assign res_addr = r_res_addr;
   assign result   = r_result;
   assign res_err  = r_res_err;

endmodule

// File: tb/tb_instr_exec_unit.sv
// tb/tb_instr_exec_unit.sv - scoreboard bench with directed and randomized runs against a reference model
module tb_instr_exec_unit;
   import instr_register_pkg::*;

   localparam int RESULT_W = 64;

   logic                       clk = 1'b0;
   logic                       reset;
   logic                       start;
   address_t                   start_addr;
   logic [5:0]                 num_instr;
   address_t                   read_pointer;
   instruction_t               instruction_word;
   logic                       res_valid;
   logic                       res_ready;
   address_t                   res_addr;
   logic signed [RESULT_W-1:0] result;
   logic                       res_err;
   logic                       busy;
   logic                       done;
`ifdef INSTR_EXEC_ERRCNT_EN
   logic [7:0]                 err_count;
`endif

   logic [67:0] mem [32];

   typedef struct {
      address_t addr;
      longint   res;
      logic     err;
   } exp_t;

   exp_t sb_q[$];
   int   checks     = 0;
   int   errors     = 0;
   int   model_errs = 0;

   instr_exec_unit #(.RESULT_W(RESULT_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .start_addr       (start_addr),
      .num_instr        (num_instr),
      .read_pointer     (read_pointer),
      .instruction_word (instruction_word),
      .res_valid        (res_valid),
      .res_ready        (res_ready),
      .res_addr         (res_addr),
      .result           (result),
      .res_err          (res_err),
      .busy             (busy),
`ifdef INSTR_EXEC_ERRCNT_EN
      .err_count        (err_count),
`endif
      .done             (done)
   );

   assign instruction_word = mem[read_pointer];

   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [67:0] mk(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      return {o, a, b};
   endfunction

   // reference model: plain 64-bit signed arithmetic on the stored word
   function automatic exp_t model(input int slot);
      logic [67:0] w;
      longint      x;
      longint      y;
      exp_t        e;
      w      = mem[slot % 32];
      x      = longint'(signed'(w[63:32]));
      y      = longint'(signed'(w[31:0]));
      e.addr = address_t'(slot % 32);
      e.res  = 0;
      e.err  = 1'b0;
      case (w[67:64])
         4'd0: e.res = 0;
         4'd1: e.res = x;
         4'd2: e.res = y;
         4'd3: e.res = x + y;
         4'd4: e.res = x - y;
         4'd5: e.res = x * y;
         4'd6: if (y == 0) e.err = 1'b1; else e.res = x / y;
         4'd7: if (y == 0) e.err = 1'b1; else e.res = x % y;
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!reset && res_valid && res_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_result_addr", longint'(res_addr), -1);
         end else begin
            e = sb_q.pop_front();
            chk("res_addr", longint'(res_addr), longint'(e.addr));
            chk("result", result, e.res);
            chk("res_err", longint'(res_err), longint'(e.err));
            if (e.err && model_errs < 255) model_errs++;
         end
      end
   end

   task automatic issue_raw(input int addr, input int n);
      start_addr = address_t'(addr);
      num_instr  = 6'(n);
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic issue(input int addr, input int n);
      for (int i = 0; i < n; i++) sb_q.push_back(model(addr + i));
      issue_raw(addr, n);
   endtask

   task automatic finish_run(input int pct);
      bit seen = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         res_ready = ($urandom_range(0, 99) < pct);
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("run_done_seen", longint'(seen), 1);
      res_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wait_valid();
      bit seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (res_valid) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("valid_seen", longint'(seen), 1);
   endtask

   task automatic rand_fill();
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 32; i++) begin
         a = $urandom();
         b = $urandom();
         if ($urandom_range(0, 5) == 0) b = 32'h0;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
         if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 40)) - 32'd20;
         mem[i] = mk(4'($urandom_range(0, 9)), a, b);
      end
   endtask

   initial begin
      int lat;
      reset      = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      num_instr  = '0;
      res_ready  = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_read_pointer", longint'(read_pointer), 0);
      chk("rst_res_valid", longint'(res_valid), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_result", result, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // single ADD: latency and done timing
      mem[3] = mk(ADD, 32'd5, -32'sd7);
      res_ready = 1'b1;
      sb_q.push_back('{5'd3, -64'sd2, 1'b0});
      start_addr = 5'd3;
      num_instr  = 6'd1;
      start      = 1'b1;
      lat        = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         if (res_valid) begin
            lat = k;
            break;
         end
      end
      chk("add_latency", lat, 3);
      chk("add_result", result, -2);
      @(posedge clk); #1;
      @(negedge clk);
      chk("add_done_pulse", longint'(done), 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("add_done_low", longint'(done), 0);
      chk("add_idle", longint'(busy), 0);
      res_ready = 1'b0;
      @(posedge clk); #1;

      // backpressure: first result held for a 4-cycle stall
      mem[10] = mk(SUB, 32'd100, 32'd1);
      mem[11] = mk(PASSB, 32'd0, 32'd42);
      sb_q.push_back('{5'd10, 64'sd99, 1'b0});
      sb_q.push_back('{5'd11, 64'sd42, 1'b0});
      issue_raw(10, 2);
      wait_valid();
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("stall_valid", longint'(res_valid), 1);
         chk("stall_result", result, 99);
         chk("stall_addr", longint'(res_addr), 10);
         chk("stall_no_fetch", longint'(read_pointer), 0);
      end
      @(posedge clk); #1;
      finish_run(100);

      // pointer wrap 30,31,0,1
      rand_fill();
      issue(30, 4);
      finish_run(60);

      // divide by zero then a valid modulo
      mem[12] = mk(DIV, 32'd9, 32'd0);
      mem[13] = mk(MOD, -32'sd7, 32'd2);
      model_errs = 0;
      sb_q.push_back('{5'd12, 64'sd0, 1'b1});
      sb_q.push_back('{5'd13, -64'sd1, 1'b0});
      issue_raw(12, 2);
      finish_run(100);
`ifdef INSTR_EXEC_ERRCNT_EN
      chk("err_count_div0", longint'(err_count), 1);
`endif

      // MULT of two max positive operands
      mem[2] = mk(MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      sb_q.push_back('{5'd2, 64'h3FFF_FFFF_0000_0001, 1'b0});
      issue_raw(2, 1);
      finish_run(100);

      // num_instr = 0
      issue_raw(7, 0);
      @(negedge clk);
      chk("zero_done", longint'(done), 1);
      chk("zero_no_valid", longint'(res_valid), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("zero_idle", longint'(busy), 0);
      @(posedge clk); #1;

      // start pulsed while busy is ignored
      rand_fill();
      issue(0, 2);
      @(posedge clk); #1;
      issue_raw(15, 5);
      finish_run(50);
      chk("busy_start_queue", sb_q.size(), 0);

      // reset in the middle of a 5-instruction run
      rand_fill();
      issue(5, 5);
      wait_valid();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_read_pointer", longint'(read_pointer), 0);
      chk("midrst_res_valid", longint'(res_valid), 0);
      chk("midrst_res_addr", longint'(res_addr), 0);
      chk("midrst_result", result, 0);
      chk("midrst_res_err", longint'(res_err), 0);
      chk("midrst_busy", longint'(busy), 0);
      chk("midrst_done", longint'(done), 0);
`ifdef INSTR_EXEC_ERRCNT_EN
      chk("midrst_err_count", longint'(err_count), 0);
`endif
      @(posedge clk); #1;
      reset = 1'b0;
      sb_q.delete();
      model_errs = 0;
      issue(20, 2);
      finish_run(100);

      // randomized runs
      for (int r = 0; r < 15; r++) begin
         rand_fill();
         issue($urandom_range(0, 31), $urandom_range(0, 32));
         finish_run($urandom_range(30, 100));
`ifdef INSTR_EXEC_ERRCNT_EN
         chk("err_count_rand", longint'(err_count), model_errs);
`endif
      end

      chk("final_queue_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_exec_unit.md
INSTR_EXEC_UNIT -- requirements
Module: instr_exec_unit

Interface
REQ-001 SHALL have parameter RESULT_W, default 64, result width in bits (minimum 64).
REQ-002 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit, single-cycle request to begin a run.
REQ-005 SHALL have port start_addr, input, address_t (5 bits), first register slot to execute.
REQ-006 SHALL have port num_instr, input, 6 bits, number of instructions to execute (0..32).
REQ-007 SHALL have port read_pointer, output, address_t, slot address driven to the instruction register.
REQ-008 SHALL have port instruction_word, input, instruction_t, combinational read data returned for read_pointer.
REQ-009 SHALL have port res_valid, output, 1 bit, result available.
REQ-010 SHALL have port res_ready, input, 1 bit, downstream accepts the result.
REQ-011 SHALL have port res_addr, output, address_t, slot that produced the result.
REQ-012 SHALL have port result, output, signed RESULT_W bits, computed value.
REQ-013 SHALL have port res_err, output, 1 bit, divide or modulo by zero on this result.
REQ-014 SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-015 SHALL have port done, output, 1 bit, one-cycle pulse at end of run.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, EXEC, OUTPUT, DONE.
REQ-017 SHALL in IDLE, on start=1 with num_instr>0: load pointer=start_addr, count=num_instr, go to FETCH; with num_instr=0: go to DONE.
REQ-018 SHALL in FETCH drive read_pointer=pointer and register instruction_word at cycle end, then go to EXEC.
REQ-019 SHALL in EXEC compute and register result, res_addr, res_err, then go to OUTPUT (start-to-first res_valid = 3 cycles).
REQ-020 SHALL in OUTPUT hold res_valid=1 and result/res_addr/res_err stable until res_ready=1; on acceptance decrement count, increment pointer, go to FETCH if count>1 else DONE.
REQ-021 SHALL in DONE assert done for exactly one cycle, then return to IDLE.
REQ-022 SHALL ignore start whenever busy=1.
REQ-023 SHALL wrap pointer 31 -> 0.
REQ-024 SHALL sign-extend operands to RESULT_W: ZERO=0, PASSA=a, PASSB=b, ADD=a+b, SUB=a-b, MULT=a*b (full product), DIV=a/b, MOD=a%b (truncate toward zero).
REQ-025 SHALL, for DIV or MOD with b=0, produce result=0 and res_err=1; res_err=0 otherwise.
REQ-026 SHALL produce result=0 and res_err=1 for any opcode encoding outside opcode_t.
REQ-027 SHALL drive read_pointer=0 in every state except FETCH.

Reset
REQ-028 SHALL on reset=1, including mid-run, enter IDLE and clear pointer and count; read_pointer, res_valid, res_addr, result, res_err, busy and done SHALL all be 0 on the following cycle.
REQ-029 SHALL give reset priority over start and res_ready.

Configuration
REQ-030 SHALL, with INSTR_EXEC_ERRCNT_EN defined, add output port err_count (8 bits): cleared by reset, incremented on each accepted result with res_err=1, saturating at 255, and not cleared by start.
REQ-031 SHALL, without INSTR_EXEC_ERRCNT_EN, omit err_count and its counter entirely.

Structure
REQ-032 SHALL import operand_t (signed 32), opcode_t (ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD), address_t and instruction_t from instr_register_pkg.
REQ-033 SHALL add result_t (signed 64) and exec_state_t to instr_register_pkg.
REQ-034 SHALL place the arithmetic in a combinational sub-module instr_alu; the FSM, counters and registers remain in instr_exec_unit.

Verification
REQ-035 Single ADD: slot 3 = {ADD, 5, -7}, start_addr=3, num_instr=1, res_ready=1 -> res_valid 3 cycles after start, result=-2, res_addr=3, done 1 cycle after acceptance.
REQ-036 Backpressure: 2 instructions, res_ready=0 for 4 cycles -> res_valid and the first result held stable for the whole stall, no FETCH until acceptance.
REQ-037 Wrap: start_addr=30, num_instr=4 -> res_addr sequence 30, 31, 0, 1.
REQ-038 Divide by zero: {DIV, 9, 0} then {MOD, -7, 2} -> result 0 with res_err=1, then result -1 with res_err=0; err_count=1 when INSTR_EXEC_ERRCNT_EN is defined.
REQ-039 Reset mid-run: reset asserted while in OUTPUT of a 5-instruction run -> all outputs 0 next cycle, IDLE; a new start then begins at the new start_addr.
REQ-040 Corner cases: num_instr=0 -> done 1 cycle after start, no res_valid; start pulsed while busy -> ignored; MULT {MULT, 32'h7FFFFFFF, 32'h7FFFFFFF} -> 64'h3FFFFFFF00000001.
